// File: rtl/du_tx_arbiter.sv
// Round-robin arbiter that shares the debug unit's UART transmitter between word-dump requesters.
// The granted word is latched and sent LSB-first, one byte per tx_start/tx_done handshake.
module du_tx_arbiter #(
   parameter int N_REQ    = 4,
   parameter int NB_DATA  = 32,
   parameter int N_BITS   = 8,
   parameter int NB_STATE = 3
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*NB_DATA-1:0] i_data,
   input  logic [N_REQ*2-1:0]       i_nbytes,
   input  logic                     i_tx_done,
   output logic                     o_tx_start,
   output logic [N_BITS-1:0]        o_tx_byte,
   output logic [N_REQ-1:0]         o_grant,
   output logic [N_REQ-1:0]         o_done,
   output logic                     o_busy,
   output logic [NB_STATE-1:0]      o_state
);

   localparam int NB_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      SEND = 3'b010,
      WAIT = 3'b100
   } state_t;

   state_t             state;
   logic [NB_IDX-1:0]  last;
   logic [NB_IDX-1:0]  owner;
   logic [NB_IDX-1:0]  win_idx;
   logic [NB_IDX-1:0]  cand;
   logic               win_found;
   logic [NB_DATA-1:0] word;
   logic [NB_DATA-1:0] win_word;
   logic [1:0]         count;
   logic [1:0]         idx;
   logic [1:0]         win_nbytes;

   // Search starts just after the previous owner, so a finished requester goes to the back.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last;
      cand      = last;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = NB_IDX'((int'(last) + k) % N_REQ);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_word   = i_data[int'(win_idx)*NB_DATA +: NB_DATA];
   assign win_nbytes = i_nbytes[2*int'(win_idx) +: 2];
   assign o_state    = NB_STATE'(state);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state      <= IDLE;
         last       <= NB_IDX'(N_REQ - 1);
         owner      <= '0;
         word       <= '0;
         count      <= '0;
         idx        <= '0;
         o_tx_start <= 1'b0;
         o_tx_byte  <= '0;
         o_grant    <= '0;
         o_done     <= '0;
         o_busy     <= 1'b0;
      end else begin
         o_done <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  owner      <= win_idx;
                  word       <= win_word;
                  count      <= win_nbytes;
                  idx        <= '0;
                  o_grant    <= N_REQ'(1) << win_idx;
                  o_busy     <= 1'b1;
                  o_tx_byte  <= win_word[N_BITS-1:0];
                  o_tx_start <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               o_tx_start <= 1'b0;
               state      <= WAIT;
            end
            WAIT: begin
               if (i_tx_done) begin
                  if (idx < count) begin
                     idx        <= idx + 2'd1;
                     o_tx_byte  <= word[N_BITS*(int'(idx)+1) +: N_BITS];
                     o_tx_start <= 1'b1;
                     state      <= SEND;
                  end else begin
                     o_done  <= N_REQ'(1) << owner;
                     o_grant <= '0;
                     o_busy  <= 1'b0;
                     last    <= owner;
                     idx     <= '0;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/du_tx_arbiter.md
Name: du_tx_arbiter

Overview:
- Shares the debug unit's single UART transmitter between N_REQ word-dump requesters: program counter, cycle count, register file and data memory.
- Round-robin arbitration.
- Serialises the granted 1..4-byte word LSB-first into the UART tx_start/tx_done handshake.
- Returns a per-requester completion pulse.
- Sits between the debug-unit dump sequencer and the UART transmitter.

Parameters:
N_REQ, 4, number of requesters (>=2)
NB_DATA, 32, word width per requester
N_BITS, 8, UART byte width
NB_STATE, 3, width of debug state output

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_req  in  N_REQ  per-requester send request, level, held until o_done
i_data  in  N_REQ*NB_DATA  word of requester k at [k*NB_DATA +: NB_DATA]
i_nbytes  in  N_REQ*2  bytes-minus-one for requester k at [2k +: 2] (0→1 byte ... 3→4 bytes)
i_tx_done  in  1  UART byte-finished pulse
o_tx_start  out  1  one-cycle UART start pulse
o_tx_byte  out  N_BITS  byte to transmit
o_grant  out  N_REQ  one-hot owner of transmitter, held for whole transfer
o_done  out  N_REQ  one-cycle completion pulse to owner
o_busy  out  1  transfer in progress
o_state  out  NB_STATE  FSM state, for debug

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All outputs 0; state IDLE.
  - Byte index 0.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
  - Reset mid-transfer aborts silently: no o_done, UART byte in flight is abandoned.
- All outputs registered. States: IDLE=3'b001, SEND=3'b010, WAIT=3'b100.
- IDLE:
  - If any i_req, pick winner w = first set bit searching (last+1), (last+2), ... mod N_REQ.
  - Next edge: o_grant=onehot(w), o_busy=1.
  - Latch word=i_data[w], count=i_nbytes[w], idx=0.
  - o_tx_byte=word[7:0], o_tx_start=1, state→SEND.
  - No request: stay IDLE.
- SEND: lasts exactly one cycle. o_tx_start cleared on next edge; state→WAIT.
- WAIT:
  - o_tx_byte held stable; wait for i_tx_done.
  - On i_tx_done with idx<count: idx+1, o_tx_byte=word[8*(idx+1) +: 8], o_tx_start=1, →SEND.
  - On i_tx_done with idx==count: o_done[w]=1 for one cycle, o_grant=0, o_busy=0, last=w, idx=0, →IDLE.
- Latency:
  - Request to first o_tx_start: 1 edge.
  - Last i_tx_done to o_done: 1 edge.
  - Earliest re-arbitration: the cycle after o_done.
- Word and count are latched at grant. i_data/i_nbytes changes and i_req deassertion during a transfer are ignored; the transfer completes and o_done still pulses.
- i_tx_done in IDLE or SEND is ignored.
- Requester that drops i_req before grant is simply not selected.
- Fairness: after owner w completes, every other pending requester is served before w again. A requester re-asserting in the o_done cycle goes to the back.
- Simultaneous requests in IDLE: exactly one grant; o_grant is always one-hot or zero.
- Only one of o_tx_start/o_done can be high per cycle.

Test Plan:
1. Reset held low, then released, with i_req=4'b0000 → all outputs 0, o_state=3'b001 indefinitely; assert i_reset=0 mid-transfer → outputs 0 within same cycle, no o_done.
2. i_req=4'b0001, i_data[0]=32'h000000A5, i_nbytes[0]=0 → o_grant=4'b0001, one o_tx_start with o_tx_byte=8'hA5; after i_tx_done, o_done=4'b0001 one cycle later, o_busy falls.
3. i_req=4'b0100, i_data[2]=32'hDEADBEEF, i_nbytes[2]=3 → four o_tx_start pulses, bytes EF, BE, AD, DE in order, each only after the prior i_tx_done; single o_done=4'b0100.
4. i_req=4'b1111 held continuously, all nbytes=0 → grant order 0,1,2,3,0,1; never two grants overlap; o_tx_start count equals i_tx_done count.
5. Requester 1 granted for 4 bytes, then i_req[1] and i_data[1] change after the first byte → remaining bytes come from the latched word; o_done[1] still pulses.
6. Spurious i_tx_done pulses in IDLE and in the SEND cycle → no state change, no extra byte sent, byte index unaffected.
